mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline register with explicit ports, valid/stall/flush control and precise-exception capture. It sits between the data-memory stage (cache, DTLB) and register-file writeback. It records the first faulting instruction, either an upstream exception or a DTLB miss, with a cause code and faulting address. It then suppresses younger instructions until the pipeline is flushed.

---
 rtl/mem_wb_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register with valid/stall/flush control and precise
// exception capture. The first faulting instruction (upstream exception or
// DTLB miss) is registered with a cause code and faulting address. The block
// then enters TRAP and feeds bubbles to writeback until the pipeline is
// flushed.
//
// Optional feature macro: MEM_WB_PERF_EN
//   When defined, adds the 32-bit wrapping counters perf_retired and
//   perf_stalls. When undefined, those ports and counters do not exist.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   in_valid                 MEM stage holds a real instruction
//   in_result, in_read_data  ALU result and cache read data
//   in_rd                    destination register index
//   in_mem_to_reg            write back read data instead of result
//   in_reg_write             instruction writes the register file
//   in_pc                    instruction PC
//   in_exception             exception raised by an earlier stage
//   in_faulty_address        faulting address that goes with in_exception
//   in_mem_enable            instruction accesses data memory
//   in_mem_address           data-memory address (reported on DTLB miss)
//   dtlb_miss, dtlb_ready    DTLB lookup missed / lookup result valid
//   stall                    hold all registers
//   flush                    load a bubble and leave TRAP (beats stall)
//   wb_*                     registered stage contents
//   wb_write_data            wb_mem_to_reg ? wb_read_data : wb_result
//   wb_reg_write             wb_valid & reg_write & !wb_exception
//   wb_cause                 0 none, 1 upstream, 2 DTLB miss
//   exc_pending              block is in TRAP
//   perf_retired/perf_stalls performance counters (MEM_WB_PERF_EN only)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_exception,
  input  logic [ADDR_W-1:0] in_faulty_address,
  input  logic              in_mem_enable,
  input  logic [ADDR_W-1:0] in_mem_address,
  input  logic              dtlb_miss,
  input  logic              dtlb_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_write_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [ADDR_W-1:0] wb_pc,
  output logic              wb_exception,
  output logic [1:0]        wb_cause,
  output logic [ADDR_W-1:0] wb_faulty_address,
  output logic              exc_pending
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stalls
`endif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_UPSTREAM = 2'd1;
  localparam logic [1:0] CAUSE_DTLB     = 2'd2;

  // Stage registers
  logic [0:0]        r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_read_data;
  logic [REG_W-1:0]  r_rd;
  logic              r_mem_to_reg;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_pc;
  logic              r_exception;
  logic [1:0]        r_cause;
  logic [ADDR_W-1:0] r_faulty_address;

  // Next-state values
  logic [0:0]        w_state_next;
  logic              w_valid_next;
  logic [DATA_W-1:0] w_result_next;
  logic [DATA_W-1:0] w_read_data_next;
  logic [REG_W-1:0]  w_rd_next;
  logic              w_mem_to_reg_next;
  logic              w_reg_write_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_exception_next;
  logic [1:0]        w_cause_next;
  logic [ADDR_W-1:0] w_faulty_address_next;

  // Fault qualification for the instruction presented this cycle.
  // A miss only counts when the lookup is valid and the instruction actually
  // touches memory; upstream exceptions outrank a DTLB miss.
  logic w_load;
  logic w_dmiss;
  logic w_exc_up;
  logic w_exc_dtlb;
  logic w_fault;

  assign w_load     = !flush && !stall;
  assign w_dmiss    = dtlb_miss && dtlb_ready && in_mem_enable;
  assign w_exc_up   = in_valid && in_exception;
  assign w_exc_dtlb = in_valid && !in_exception && w_dmiss;
  assign w_fault    = w_exc_up || w_exc_dtlb;

  always_comb begin
    // Default: hold (covers stall without flush)
    w_state_next          = r_state;
    w_valid_next          = r_valid;
    w_result_next         = r_result;
    w_read_data_next      = r_read_data;
    w_rd_next             = r_rd;
    w_mem_to_reg_next     = r_mem_to_reg;
    w_reg_write_next      = r_reg_write;
    w_pc_next             = r_pc;
    w_exception_next      = r_exception;
    w_cause_next          = r_cause;
    w_faulty_address_next = r_faulty_address;

    if (flush || (w_load && (r_state == ST_TRAP))) begin
      // Bubble. Flush additionally leaves TRAP; a plain load in TRAP stays.
      w_state_next          = flush ? ST_RUN : r_state;
      w_valid_next          = 1'b0;
      w_result_next         = '0;
      w_read_data_next      = '0;
      w_rd_next             = '0;
      w_mem_to_reg_next     = 1'b0;
      w_reg_write_next      = 1'b0;
      w_pc_next             = '0;
      w_exception_next      = 1'b0;
      w_cause_next          = CAUSE_NONE;
      w_faulty_address_next = '0;
    end else if (w_load) begin
      // RUN: capture the incoming instruction, enter TRAP on a fault
      w_state_next          = w_fault ? ST_TRAP : ST_RUN;
      w_valid_next          = in_valid;
      w_result_next         = in_result;
      w_read_data_next      = in_read_data;
      w_rd_next             = in_rd;
      w_mem_to_reg_next     = in_mem_to_reg;
      w_reg_write_next      = in_reg_write;
      w_pc_next             = in_pc;
      w_exception_next      = w_fault;
      if (w_exc_up) begin
        w_cause_next          = CAUSE_UPSTREAM;
        w_faulty_address_next = in_faulty_address;
      end else if (w_exc_dtlb) begin
        w_cause_next          = CAUSE_DTLB;
        w_faulty_address_next = in_mem_address;
      end else begin
        w_cause_next          = CAUSE_NONE;
        w_faulty_address_next = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_RUN;
      r_valid          <= 1'b0;
      r_result         <= '0;
      r_read_data      <= '0;
      r_rd             <= '0;
      r_mem_to_reg     <= 1'b0;
      r_reg_write      <= 1'b0;
      r_pc             <= '0;
      r_exception      <= 1'b0;
      r_cause          <= CAUSE_NONE;
      r_faulty_address <= '0;
    end else begin
      r_state          <= w_state_next;
      r_valid          <= w_valid_next;
      r_result         <= w_result_next;
      r_read_data      <= w_read_data_next;
      r_rd             <= w_rd_next;
      r_mem_to_reg     <= w_mem_to_reg_next;
      r_reg_write      <= w_reg_write_next;
      r_pc             <= w_pc_next;
      r_exception      <= w_exception_next;
      r_cause          <= w_cause_next;
      r_faulty_address <= w_faulty_address_next;
    end
  end

`ifdef MEM_WB_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_stalls;
  logic        w_retire;

  // Counts only instructions captured in RUN that carry no fault
  assign w_retire = w_load && (r_state == ST_RUN) && in_valid && !w_fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_retired <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_retire) begin
        r_perf_retired <= r_perf_retired + 32'd1;
      end
      if (stall && !flush) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_retired = r_perf_retired;
  assign perf_stalls  = r_perf_stalls;
`endif

  assign wb_valid          = r_valid;
  assign wb_result         = r_result;
  assign wb_read_data      = r_read_data;
  assign wb_write_data     = r_mem_to_reg ? r_read_data : r_result;
  assign wb_rd             = r_rd;
  assign wb_mem_to_reg     = r_mem_to_reg;
  assign wb_reg_write      = r_valid && r_reg_write && !r_exception;
  assign wb_pc             = r_pc;
  assign wb_exception      = r_exception;
  assign wb_cause          = r_cause;
  assign wb_faulty_address = r_faulty_address;
  assign exc_pending       = (r_state == ST_TRAP);

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_result;
  logic [31:0] in_read_data;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [31:0] in_pc;
  logic        in_exception;
  logic [31:0] in_faulty_address;
  logic        in_mem_enable;
  logic [31:0] in_mem_address;
  logic        dtlb_miss;
  logic        dtlb_ready;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [31:0] wb_read_data;
  logic [31:0] wb_write_data;
  logic [4:0]  wb_rd;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [31:0] wb_pc;
  logic        wb_exception;
  logic [1:0]  wb_cause;
  logic [31:0] wb_faulty_address;
  logic        exc_pending;
  logic [31:0] perf_retired;
  logic [31:0] perf_stalls;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_result(in_result), .in_read_data(in_read_data),
    .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_pc(in_pc), .in_exception(in_exception),
    .in_faulty_address(in_faulty_address), .in_mem_enable(in_mem_enable),
    .in_mem_address(in_mem_address), .dtlb_miss(dtlb_miss),
    .dtlb_ready(dtlb_ready), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_read_data(wb_read_data),
    .wb_write_data(wb_write_data), .wb_rd(wb_rd),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_pc(wb_pc), .wb_exception(wb_exception), .wb_cause(wb_cause),
    .wb_faulty_address(wb_faulty_address), .exc_pending(exc_pending)
`ifdef MEM_WB_PERF_EN
    , .perf_retired(perf_retired), .perf_stalls(perf_stalls)
`endif
  );

`ifndef MEM_WB_PERF_EN
  assign perf_retired = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] read_data;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] pc;
    logic        exception;
    logic [1:0]  cause;
    logic [31:0] faulty_address;
    logic        exc_pending;
  } out_t;

  typedef struct packed {
    out_t        o;
    logic [31:0] retired;
    logic [31:0] stalls;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what writeback should show, whether a trap is
  // outstanding, and the expected counter values.
  out_t        m_out;
  bit          m_trap;
  logic [31:0] m_retired;
  logic [31:0] m_stalls;

  int tests  = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t sample_dut();
    out_t a;
    a.valid          = wb_valid;
    a.result         = wb_result;
    a.read_data      = wb_read_data;
    a.write_data     = wb_write_data;
    a.rd             = wb_rd;
    a.mem_to_reg     = wb_mem_to_reg;
    a.reg_write      = wb_reg_write;
    a.pc             = wb_pc;
    a.exception      = wb_exception;
    a.cause          = wb_cause;
    a.faulty_address = wb_faulty_address;
    a.exc_pending    = exc_pending;
    return a;
  endfunction

  task automatic check_out(input string name, input out_t exp_o,
                           input logic [31:0] exp_ret, input logic [31:0] exp_stl);
    out_t act;
    act = sample_dut();
    tests++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_o);
    end else begin
      $display("[TB] %s ok: valid=%0d rd=%0d wdata=%h exc=%0d cause=%0d fa=%h trap=%0d",
               name, act.valid, act.rd, act.write_data, act.exception,
               act.cause, act.faulty_address, act.exc_pending);
    end
`ifdef MEM_WB_PERF_EN
    tests++;
    if (perf_retired !== exp_ret || perf_stalls !== exp_stl) begin
      errors++;
      $display("FAIL %s_perf: got retired=%0d stalls=%0d expected retired=%0d stalls=%0d",
               name, perf_retired, perf_stalls, exp_ret, exp_stl);
    end
`else
    if (exp_ret === 32'hxxxx_xxxx && exp_stl === 32'hxxxx_xxxx) $display("[TB] unexpected");
`endif
  endtask

  // Monitor: every rising edge produces one writeback state, compared
  // against the oldest expectation pushed by the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("wb_cycle", e.o, e.retired, e.stalls);
      end
    end
  end

  task automatic set_idle();
    in_valid = 0; in_result = 0; in_read_data = 0; in_rd = 0;
    in_mem_to_reg = 0; in_reg_write = 0; in_pc = 0; in_exception = 0;
    in_faulty_address = 0; in_mem_enable = 0; in_mem_address = 0;
    dtlb_miss = 0; dtlb_ready = 0; stall = 0; flush = 0;
  endtask

  task automatic model_reset();
    m_out = '0; m_trap = 0; m_retired = 0; m_stalls = 0;
  endtask

  // Apply the stage rules to the currently driven inputs, push the result,
  // and advance to the next falling edge.
  task automatic step();
    exp_t e;
    bit   fault;
    bit   up;
    up    = in_valid && in_exception;
    fault = up || (in_valid && dtlb_miss && dtlb_ready && in_mem_enable);
    if (stall && !flush) m_stalls = m_stalls + 1;
    if (flush) begin
      m_out  = '0;
      m_trap = 0;
    end else if (!stall) begin
      if (m_trap) begin
        m_out = '0;
      end else begin
        if (in_valid && !fault) m_retired = m_retired + 1;
        m_out.valid          = in_valid;
        m_out.result         = in_result;
        m_out.read_data      = in_read_data;
        m_out.write_data     = in_mem_to_reg ? in_read_data : in_result;
        m_out.rd             = in_rd;
        m_out.mem_to_reg     = in_mem_to_reg;
        m_out.reg_write      = in_valid && in_reg_write && !fault;
        m_out.pc             = in_pc;
        m_out.exception      = fault;
        m_out.cause          = !fault ? 2'd0 : (up ? 2'd1 : 2'd2);
        m_out.faulty_address = !fault ? 32'd0 : (up ? in_faulty_address : in_mem_address);
        m_trap = fault;
      end
    end
    m_out.exc_pending = m_trap;
    e.o = m_out; e.retired = m_retired; e.stalls = m_stalls;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic drive_valid(input logic [31:0] res, input logic [31:0] rdata,
                             input logic [4:0] rd);
    set_idle();
    in_valid = 1; in_result = res; in_read_data = rdata; in_rd = rd;
    in_reg_write = 1; in_mem_to_reg = rd[0]; in_pc = res + 32'h4000;
  endtask

  initial begin
    out_t zero_o;
    zero_o = '0;
    set_idle();
    model_reset();
    reset_n = 0;
    #3;
    check_out("reset", zero_o, 0, 0);
    @(negedge clock);
    reset_n = 1;

    // Load from memory: write data must come from read data
    drive_valid(32'h11, 32'h22, 5'd3); in_mem_to_reg = 1; step();
    drive_valid(32'h33, 32'h44, 5'd4); in_mem_to_reg = 0; step();

    // DTLB miss at 0x1000, then three valid inputs swallowed, then flush
    drive_valid(32'h55, 32'h66, 5'd5);
    in_mem_enable = 1; in_mem_address = 32'h1000; dtlb_miss = 1; dtlb_ready = 1;
    step();
    for (int i = 0; i < 3; i++) begin drive_valid(32'h70 + i, 32'h80 + i, 5'd6); step(); end
    set_idle(); flush = 1; step();
    drive_valid(32'h99, 32'hAA, 5'd7); step();

    // Upstream exception beats a simultaneous DTLB miss
    drive_valid(32'h12, 32'h34, 5'd8);
    in_exception = 1; in_faulty_address = 32'hA0;
    in_mem_enable = 1; in_mem_address = 32'hB0; dtlb_miss = 1; dtlb_ready = 1;
    step();
    set_idle(); flush = 1; step();

    // Miss without ready is ignored
    drive_valid(32'h21, 32'h43, 5'd9);
    in_mem_enable = 1; in_mem_address = 32'hC0; dtlb_miss = 1; dtlb_ready = 0;
    step();

    // Stall for 4 cycles with changing inputs, one of them a miss
    for (int i = 0; i < 4; i++) begin
      drive_valid($urandom, $urandom, 5'(i + 10)); stall = 1;
      in_mem_enable = 1; dtlb_miss = (i == 2); dtlb_ready = 1;
      step();
    end
    // Stall plus faulting flush: flush wins, no trap, stall count unchanged
    drive_valid(32'hDD, 32'hEE, 5'd15); stall = 1; flush = 1; in_exception = 1;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid          = ($urandom % 4) != 0;
      in_result         = $urandom;
      in_read_data      = $urandom;
      in_rd             = 5'($urandom);
      in_mem_to_reg     = 1'($urandom);
      in_reg_write      = 1'($urandom);
      in_pc             = $urandom;
      in_exception      = ($urandom % 20) == 0;
      in_faulty_address = $urandom;
      in_mem_enable     = 1'($urandom);
      in_mem_address    = $urandom;
      dtlb_miss         = ($urandom % 6) == 0;
      dtlb_ready        = ($urandom % 3) != 0;
      stall             = ($urandom % 8) == 0;
      flush             = ($urandom % 12) == 0;
      step();
    end

    // Enter TRAP, then assert reset between edges
    set_idle(); flush = 1; step();
    drive_valid(32'h5A, 32'hA5, 5'd1);
    in_mem_enable = 1; in_mem_address = 32'h2000; dtlb_miss = 1; dtlb_ready = 1;
    step();
    set_idle();
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check_out("reset_mid_trap", zero_o, 0, 0);
    @(negedge clock);
    reset_n = 1;
    drive_valid(32'h77, 32'h88, 5'd2); step();
    set_idle(); step();

    @(posedge clock);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
